// File: rtl/gp_pkg.sv
// Shared constants and types for the graphics-processor arbiter.
// Screen geometry sets the coordinate widths so the two cannot drift apart.
package gp_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int GP_X_W   = $clog2(SCREEN_W);
  localparam int GP_Y_W   = $clog2(SCREEN_H);
  localparam int GP_ARG_W = 12;

  localparam logic GP_OP_CLEAR = 1'b0;
  localparam logic GP_OP_FILL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CLR = 2'd1,
    BUSY     = 2'd2,
    DONE     = 2'd3
  } gp_state_e;

endpackage

// File: rtl/gp_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from last_owner+1 (wrapping) and
// returns the first requesting index as one-hot, binary index and valid.
module rr_pick #(
  parameter  int N_REQ = 3,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_owner,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    index,
  output logic             valid
);

  int          c;
  logic [IW-1:0] cidx;

  always_comb begin
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    c      = 0;
    cidx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      c = int'(last_owner) + k;
      if (c >= N_REQ) c = c - N_REQ;
      cidx = IW'(c);
      if (!valid && req[cidx]) begin
        valid        = 1'b1;
        index        = cidx;
        onehot[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gp_arbiter.sv
// Round-robin arbiter sharing one graphics processor among N_REQ requesters.
// Optional watchdog on a stuck BUSY is enabled by defining GP_ARB_TIMEOUT_EN.
module gp_arbiter
  import gp_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_opcode,
  input  logic [GP_X_W*N_REQ-1:0]   req_tl_x,
  input  logic [GP_Y_W*N_REQ-1:0]   req_tl_y,
  input  logic [GP_X_W*N_REQ-1:0]   req_br_x,
  input  logic [GP_Y_W*N_REQ-1:0]   req_br_y,
  input  logic [GP_ARG_W*N_REQ-1:0] req_arg,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  input  logic                      gp_finish,
  output logic                      gp_en,
  output logic                      gp_opcode,
  output logic [GP_X_W-1:0]         gp_tl_x,
  output logic [GP_Y_W-1:0]         gp_tl_y,
  output logic [GP_X_W-1:0]         gp_br_x,
  output logic [GP_Y_W-1:0]         gp_br_y,
`ifdef GP_ARB_TIMEOUT_EN
  output logic                      timeout_err,
`endif
  output logic [GP_ARG_W-1:0]       gp_arg
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("gp_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  logic [GP_X_W-1:0]   tl_x_a [N_REQ];
  logic [GP_Y_W-1:0]   tl_y_a [N_REQ];
  logic [GP_X_W-1:0]   br_x_a [N_REQ];
  logic [GP_Y_W-1:0]   br_y_a [N_REQ];
  logic [GP_ARG_W-1:0] arg_a  [N_REQ];

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign tl_x_a[gi] = req_tl_x[GP_X_W*gi +: GP_X_W];
    assign tl_y_a[gi] = req_tl_y[GP_Y_W*gi +: GP_Y_W];
    assign br_x_a[gi] = req_br_x[GP_X_W*gi +: GP_X_W];
    assign br_y_a[gi] = req_br_y[GP_Y_W*gi +: GP_Y_W];
    assign arg_a[gi]  = req_arg[GP_ARG_W*gi +: GP_ARG_W];
  end

  gp_state_e           state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d, done_q, done_d;
  logic                gp_en_q, gp_en_d, op_q, op_d;
  logic [GP_X_W-1:0]   tl_x_q, tl_x_d, br_x_q, br_x_d;
  logic [GP_Y_W-1:0]   tl_y_q, tl_y_d, br_y_q, br_y_d;
  logic [GP_ARG_W-1:0] arg_q, arg_d;
  logic [IW-1:0]       last_q, last_d;
  // Blocks a grant on the first edge after reset release.
  logic                started_q;

  logic [N_REQ-1:0]    pick_onehot;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;

`ifdef GP_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                to_q, to_d;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req),
    .last_owner (last_q),
    .onehot     (pick_onehot),
    .index      (pick_idx),
    .valid      (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = done_q;
    gp_en_d = gp_en_q;
    op_d    = op_q;
    tl_x_d  = tl_x_q;
    tl_y_d  = tl_y_q;
    br_x_d  = br_x_q;
    br_y_d  = br_y_q;
    arg_d   = arg_q;
    last_d  = last_q;
`ifdef GP_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (gp_finish) begin
          state_d = WAIT_CLR;
        end else if (started_q && pick_valid) begin
          state_d = BUSY;
          grant_d = pick_onehot;
          gp_en_d = 1'b1;
          last_d  = pick_idx;
          op_d    = req_opcode[pick_idx];
          tl_x_d  = tl_x_a[pick_idx];
          tl_y_d  = tl_y_a[pick_idx];
          br_x_d  = br_x_a[pick_idx];
          br_y_d  = br_y_a[pick_idx];
          arg_d   = arg_a[pick_idx];
`ifdef GP_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT_CLR: begin
        if (!gp_finish) state_d = IDLE;
      end
      BUSY: begin
        if (gp_finish) begin
          state_d = DONE;
          gp_en_d = 1'b0;
          done_d  = grant_q;
`ifdef GP_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          gp_en_d = 1'b0;
          done_d  = grant_q;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        done_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      gp_en_q   <= 1'b0;
      op_q      <= 1'b0;
      tl_x_q    <= '0;
      tl_y_q    <= '0;
      br_x_q    <= '0;
      br_y_q    <= '0;
      arg_q     <= '0;
      last_q    <= IW'(N_REQ - 1);
      started_q <= 1'b0;
`ifdef GP_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      gp_en_q   <= gp_en_d;
      op_q      <= op_d;
      tl_x_q    <= tl_x_d;
      tl_y_q    <= tl_y_d;
      br_x_q    <= br_x_d;
      br_y_q    <= br_y_d;
      arg_q     <= arg_d;
      last_q    <= last_d;
      started_q <= 1'b1;
`ifdef GP_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      to_q      <= to_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign gp_en     = gp_en_q;
  assign gp_opcode = op_q;
  assign gp_tl_x   = tl_x_q;
  assign gp_tl_y   = tl_y_q;
  assign gp_br_x   = br_x_q;
  assign gp_br_y   = br_y_q;
  assign gp_arg    = arg_q;
`ifdef GP_ARB_TIMEOUT_EN
  assign timeout_err = to_q;
`endif

endmodule

// File: tb/tb_gp_arbiter.sv
// Directed bench for gp_arbiter: expected commands queue up as requests are
// driven and are checked against the operands latched when gp_en rises.
`timescale 1ns/1ps
module tb_gp_arbiter;
  import gp_pkg::*;

  localparam int N = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     req_opcode = '0;
  logic [10*N-1:0]  req_tl_x = '0;
  logic [9*N-1:0]   req_tl_y = '0;
  logic [10*N-1:0]  req_br_x = '0;
  logic [9*N-1:0]   req_br_y = '0;
  logic [12*N-1:0]  req_arg = '0;
  logic [N-1:0]     grant, done;
  logic             gp_finish = 1'b0;
  logic             gp_en, gp_opcode;
  logic [9:0]       gp_tl_x, gp_br_x;
  logic [8:0]       gp_tl_y, gp_br_y;
  logic [11:0]      gp_arg;
`ifdef GP_ARB_TIMEOUT_EN
  logic             timeout_err;
`endif

  gp_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_opcode (req_opcode),
    .req_tl_x   (req_tl_x),
    .req_tl_y   (req_tl_y),
    .req_br_x   (req_br_x),
    .req_br_y   (req_br_y),
    .req_arg    (req_arg),
    .grant      (grant),
    .done       (done),
    .gp_finish  (gp_finish),
    .gp_en      (gp_en),
    .gp_opcode  (gp_opcode),
    .gp_tl_x    (gp_tl_x),
    .gp_tl_y    (gp_tl_y),
    .gp_br_x    (gp_br_x),
    .gp_br_y    (gp_br_y),
`ifdef GP_ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .gp_arg     (gp_arg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    logic        op;
    logic [9:0]  tlx;
    logic [8:0]  tly;
    logic [9:0]  brx;
    logic [8:0]  bry;
    logic [11:0] arg;
  } exp_t;

  exp_t sb[$];
  exp_t ops_tab[N];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_ops(input int i, input logic op, input logic [9:0] tlx, input logic [8:0] tly,
                         input logic [9:0] brx, input logic [8:0] bry, input logic [11:0] arg);
    req_opcode[i]        = op;
    req_tl_x[10*i +: 10] = tlx;
    req_tl_y[9*i +: 9]   = tly;
    req_br_x[10*i +: 10] = brx;
    req_br_y[9*i +: 9]   = bry;
    req_arg[12*i +: 12]  = arg;
    ops_tab[i] = '{owner: i, op: op, tlx: tlx, tly: tly, brx: brx, bry: bry, arg: arg};
  endtask

  task automatic push_exp(input int i);
    sb.push_back(ops_tab[i]);
  endtask

  task automatic expect_grant(input string tag, input int budget, output int c);
    exp_t       e;
    logic [2:0] g;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!gp_en && c < budget);
    chk($sformatf("%s_gpen", tag), gp_en, 1);
    chk($sformatf("%s_sb", tag), sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = 3'b001 << e.owner;
      chk($sformatf("%s_grant", tag), grant, g);
      chk($sformatf("%s_ops", tag), {gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg},
          {e.op, e.tlx, e.tly, e.brx, e.bry, e.arg});
    end
  endtask

  task automatic finish_cmd(input string tag, input int owner, input int hold);
    logic [2:0] g;
    g = 3'b001 << owner;
    repeat (hold) @(negedge clk);
    chk($sformatf("%s_hold", tag), gp_en, 1);
    gp_finish = 1'b1;
    @(negedge clk);
    gp_finish = 1'b0;
    chk($sformatf("%s_done", tag), done, g);
    chk($sformatf("%s_enoff", tag), gp_en, 0);
    @(negedge clk);
    chk($sformatf("%s_doneclr", tag), done, 0);
    chk($sformatf("%s_idle", tag), grant, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_gpen", gp_en, 0);
    chk("rst_done", done, 0);
    chk("rst_ops", {gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg}, 0);
`ifdef GP_ARB_TIMEOUT_EN
    chk("rst_to", timeout_err, 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single request, full-screen rectangle
    set_ops(0, GP_OP_FILL, 10'd0, 9'd0, 10'd639, 9'd479, 12'h000);
    req = 3'b001;
    push_exp(0);
    expect_grant("s1", 4, cyc);
    chk("s1_lat", cyc, 1);
    req = 3'b000;
    finish_cmd("s1", 0, 9);

    // All three requesting continuously, after a fresh reset
    set_ops(0, GP_OP_CLEAR, 10'd1,   9'd2,   10'd100, 9'd50,  12'h111);
    set_ops(1, GP_OP_FILL,  10'd200, 9'd100, 10'd300, 9'd200, 12'h222);
    set_ops(2, GP_OP_CLEAR, 10'd400, 9'd300, 10'd639, 9'd479, 12'h333);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 3'b111;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_exp(k % 3);
      expect_grant($sformatf("s2_%0d", k), 4, cyc);
      chk($sformatf("s2_%0d_lat", k), cyc, (k == 0) ? 2 : 1);
      finish_cmd($sformatf("s2_%0d", k), k % 3, 2 + k);
    end

    // Owner 1 drops req and changes its argument mid-command
    push_exp(1);
    expect_grant("s3", 4, cyc);
    chk("s3_lat", cyc, 1);
    req = 3'b000;
    set_ops(1, GP_OP_CLEAR, 10'd5, 9'd5, 10'd6, 9'd6, 12'hFFF);
    repeat (3) @(negedge clk);
    chk("s3_arg_held", gp_arg, 12'h222);
    chk("s3_tlx_held", gp_tl_x, 10'd200);
    finish_cmd("s3", 1, 2);

    // gp_finish stuck high while a request waits
    gp_finish = 1'b1;
    set_ops(2, GP_OP_FILL, 10'd10, 9'd20, 10'd30, 9'd40, 12'hABC);
    req = 3'b100;
    repeat (5) @(negedge clk);
    chk("s4_nogrant", grant, 0);
    chk("s4_noen", gp_en, 0);
    gp_finish = 1'b0;
    push_exp(2);
    expect_grant("s4", 4, cyc);
    chk("s4_within2", cyc <= 2, 1);

    // Reset pulsed during that BUSY
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_gpen_async", gp_en, 0);
    chk("s5_grant_async", grant, 0);
    chk("s5_done_async", done, 0);
    set_ops(0, GP_OP_FILL, 10'd7, 9'd8, 10'd9, 9'd10, 12'h5A5);
    req = 3'b111;
    repeat (2) @(negedge clk);
    chk("s5_done_rst", done, 0);
    rst_n = 1'b1;
    push_exp(0);
    expect_grant("s5", 4, cyc);
    chk("s5_lat", cyc, 2);
    req = 3'b000;
    finish_cmd("s5", 0, 3);

`ifdef GP_ARB_TIMEOUT_EN
    // Watchdog: gp_finish never rises
    set_ops(1, GP_OP_CLEAR, 10'd11, 9'd12, 10'd13, 9'd14, 12'h0F0);
    req = 3'b010;
    push_exp(1);
    expect_grant("s6", 4, cyc);
    req = 3'b000;
    cyc = 0;
    while (gp_en && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    chk("s6_busy_cycles", cyc, 16);
    chk("s6_to", timeout_err, 1);
    chk("s6_done", done, 3'b010);
    @(negedge clk);
    chk("s6_doneclr", done, 0);
    chk("s6_to_sticky", timeout_err, 1);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/gp_arbiter.md
GP_ARBITER -- requirements
Module: gp_arbiter

Interface
REQ-001 The module SHALL have parameter N_REQ, default 3, giving the number of requesters sharing the graphics processor.
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 1048575, giving the watchdog limit in clk cycles (used only under REQ-024).
REQ-003 The module SHALL have the following ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester command request, level, held until done.
- req_opcode  in  N_REQ  per-requester opcode, 1 bit each.
- req_tl_x  in  10*N_REQ  per-requester top-left x, packed, requester i at [10i+9:10i].
- req_tl_y  in  9*N_REQ  per-requester top-left y, packed.
- req_br_x  in  10*N_REQ  per-requester bottom-right x, packed.
- req_br_y  in  9*N_REQ  per-requester bottom-right y, packed.
- req_arg  in  12*N_REQ  per-requester argument, for example colour, packed.
- grant  out  N_REQ  one-hot owner of the graphics processor; all zero when idle.
- done  out  N_REQ  one-cycle pulse to the owner when its command completes.
- gp_finish  in  1  graphics processor completion, level.
- gp_en  out  1  command valid to the graphics processor.
- gp_opcode  out  1  registered opcode.
- gp_tl_x, gp_tl_y, gp_br_x, gp_br_y  out  10/9/10/9  registered rectangle.
- gp_arg  out  12  registered argument.
- timeout_err  out  1  sticky watchdog flag (present only under REQ-024).

Function
REQ-004 The arbiter SHALL use the states IDLE, WAIT_CLR, BUSY and DONE.
REQ-005 In IDLE, with gp_finish low and any req bit set, the arbiter SHALL choose a winner per REQ-010, capture the winner's operands into the gp_* registers, set grant to that winner (one-hot), assert gp_en and move to BUSY, all on the same edge.
REQ-006 In IDLE with gp_finish high, the arbiter SHALL move to WAIT_CLR and SHALL NOT grant.
REQ-007 In WAIT_CLR, the arbiter SHALL return to IDLE on the first cycle gp_finish is low.
REQ-008 In BUSY, the arbiter SHALL hold gp_en high and all gp_* operands stable until gp_finish is sampled high; it SHALL then clear gp_en, pulse done[owner] for exactly one cycle and move to DONE.
REQ-009 In DONE, the arbiter SHALL clear grant and done, and SHALL return to IDLE.
- Minimum idle gap between commands: 1 cycle.
- Latency from req to gp_en: 1 cycle.
REQ-010 Arbitration SHALL be round-robin: the search starts at (last_owner+1) mod N_REQ and takes the first set req bit; last_owner resets to N_REQ-1, so requester 0 has first priority.
REQ-011 If req[owner] drops while in BUSY, the command SHALL still run to completion; done SHALL still pulse, and no abort is taken.
REQ-012 A requester that keeps req high after done SHALL be re-considered only in the next IDLE, behind any other pending requester.
REQ-013 Changes to req operand inputs after the grant edge SHALL NOT affect gp_* outputs.
REQ-014 If gp_finish rises in the same cycle gp_en is first asserted, the arbiter SHALL ignore it, because gp_finish is sampled only from the first BUSY cycle.
REQ-015 If gp_finish never rises, BUSY SHALL persist indefinitely when REQ-024 is disabled.

Reset
REQ-016 While rst_n is low, the arbiter SHALL force the state to IDLE, gp_en=0, grant=0, done=0, all gp_* operand registers to 0, last_owner=N_REQ-1 and timeout_err=0, asynchronously.
REQ-017 Reset asserted mid-command SHALL drop gp_en immediately, and no done SHALL be issued for the aborted command.
REQ-018 After rst_n is released, the first grant SHALL occur no earlier than the second rising clk edge.

Configuration
REQ-019 The macro GP_ARB_TIMEOUT_EN SHALL select the watchdog feature.
REQ-020 When the macro is defined, a cycle counter SHALL run while in BUSY.
REQ-021 When the counter reaches TIMEOUT_CYCLES, the arbiter SHALL clear gp_en, set timeout_err (sticky until reset), pulse done[owner] and enter DONE.
REQ-022 When the macro is defined, the counter SHALL clear on every BUSY entry.
REQ-023 When the macro is undefined, there SHALL be no counter and no timeout_err port, and REQ-015 applies.
REQ-024 REQ-020 to REQ-022 SHALL apply only with GP_ARB_TIMEOUT_EN defined.

Structure
REQ-025 A shared package gp_pkg SHALL hold the following:
- GP_OP_* opcode constants.
- SCREEN_W=640 and SCREEN_H=480.
- Coordinate widths 10 and 9, and GP_ARG_W=12.
- The arbiter state enumeration.
REQ-026 The round-robin selection SHALL be a combinational sub-module rr_pick (inputs req and last_owner; outputs onehot and index plus valid).

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Single request: req=3'b001, opcode=1, rect (0,0)-(639,479), arg=0; gp_finish rises 10 cycles after gp_en. Expected: gp_en high 1 cycle after req, operands match, done[0] pulses once, then grant=0.
- All three requesting continuously: grants in order 0,1,2,0 with one idle cycle between commands.
- Owner drops req mid-BUSY, and its operands change to arg=12'hFFF: gp_arg stays at the latched value and done still pulses.
- gp_finish stuck high at an idle request: no grant; once gp_finish falls, grant occurs within 2 cycles.
- rst_n pulsed low during BUSY: gp_en=0 and grant=0 asynchronously, no done, and requester 0 is granted first after release.
- With GP_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, gp_finish never rises: gp_en drops after 16 BUSY cycles, timeout_err=1 and done pulses.
